// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request per op on dmem, load data formatted into mem_memory_data.
// Stalls the pipeline from IDLE until DONE; MEM_ACCESS_WATCHDOG_EN adds a timeout abort.
module mem_access_unit #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_memRead,
  input  logic                    mem_memWrite,
  input  logic [2:0]              mem_funct3,
  input  logic [DATA_WIDTH-1:0]   mem_ALU_result,
  input  logic [DATA_WIDTH-1:0]   mem_store_data,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDRESS_BITS-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [3:0]              dmem_be,
  input  logic                    dmem_ready,
  input  logic                    dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic [DATA_WIDTH-1:0]   mem_memory_data,
  output logic                    mem_stall,
  output logic                    mem_access_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              off;
  logic                    any_op, bad_f3, bad_store, misalign, op_valid, op_fault;
  logic [3:0]              be_new;
  logic [DATA_WIDTH-1:0]   wdata_new;
  logic [2:0]              req_f3;
  logic [1:0]              req_off;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_fmt;
  logic                    capture, timeout, abort, done_fault;
  logic                    unused_bits;

  assign unused_bits = ^{mem_ALU_result[DATA_WIDTH-1:ADDRESS_BITS+2], CORE[0], TIMEOUT_CYCLES[0]};

  assign off       = mem_ALU_result[1:0];
  assign any_op    = mem_memRead | mem_memWrite;
  assign bad_f3    = (mem_funct3 == 3'b011) || (mem_funct3 == 3'b110) || (mem_funct3 == 3'b111);
  assign bad_store = mem_memWrite & mem_funct3[2];
  assign misalign  = ((mem_funct3[1:0] == 2'b01) && off[0]) ||
                     ((mem_funct3[1:0] == 2'b10) && (off != 2'b00));
  assign op_valid  = (mem_memRead ^ mem_memWrite) & ~bad_f3 & ~bad_store & ~misalign;
  assign op_fault  = any_op & ~op_valid;

  // Stores replicate the lane data so memory only needs the byte enables.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = mem_store_data;
    case (mem_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << off;
        wdata_new = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << off;
        wdata_new = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[{req_off, 3'b000} +: 8];
    ld_half = req_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (req_f3)
      3'b000:  ld_fmt = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (op_valid) state_nxt = REQ;
      REQ: begin
        if (dmem_ready) begin
          if (dmem_we) begin
            state_nxt = DONE;
          end else if (dmem_rvalid) begin
            capture   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end else if (timeout) begin
          state_nxt = DONE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (timeout) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ACCESS_WATCHDOG_EN
  localparam logic [7:0] WdLimit = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_cnt;
  logic       aborted;

  assign timeout    = ((state == REQ) || (state == WAIT)) && (wd_cnt == WdLimit);
  assign abort      = timeout & (((state == REQ) & ~dmem_ready) | ((state == WAIT) & ~dmem_rvalid));
  assign done_fault = aborted & (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt  <= 8'd0;
      aborted <= 1'b0;
    end else begin
      aborted <= abort;
      if (state == IDLE || state == DONE) wd_cnt <= 8'd0;
      else                                wd_cnt <= wd_cnt + 8'd1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign abort      = 1'b0;
  assign done_fault = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      dmem_we         <= 1'b0;
      dmem_addr       <= '0;
      dmem_wdata      <= '0;
      dmem_be         <= 4'b0000;
      req_f3          <= 3'b000;
      req_off         <= 2'b00;
      mem_memory_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && op_valid) begin
        dmem_we    <= mem_memWrite;
        dmem_addr  <= mem_ALU_result[ADDRESS_BITS+1:2];
        dmem_wdata <= wdata_new;
        dmem_be    <= be_new;
        req_f3     <= mem_funct3;
        req_off    <= off;
      end
      if (capture)    mem_memory_data <= ld_fmt;
      else if (abort) mem_memory_data <= '0;
    end
  end

  assign dmem_req         = (state == REQ);
  assign mem_stall        = ~reset & (((state == IDLE) & op_valid) | (state == REQ) | (state == WAIT));
  assign mem_access_fault = ~reset & (((state == IDLE) & op_fault) | done_fault);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a spec-level load/store model and per-cycle output compare.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_memRead, mem_memWrite;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_ALU_result, mem_store_data;
  logic        dmem_req, dmem_we;
  logic [19:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_memory_data;
  logic        mem_stall, mem_access_fault;

  mem_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .TIMEOUT_CYCLES(255)) dut (
    .clock(clock), .reset(reset),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_funct3(mem_funct3),
    .mem_ALU_result(mem_ALU_result), .mem_store_data(mem_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_memory_data(mem_memory_data), .mem_stall(mem_stall), .mem_access_fault(mem_access_fault)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          stall_total = 0;
  logic        exp_stall, exp_req, exp_fault, exp_we;
  logic [19:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata, exp_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    int o;
    logic [31:0] b, h;
    o = int'(a % 4);
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             output logic [3:0] be, output logic [31:0] wd);
    int o;
    o = int'(a % 4);
    case (f3)
      3'b000:  begin be = 4'(1 << o); wd = (d & 32'hFF) * 32'h0101_0101; end
      3'b001:  begin be = 4'(3 << o); wd = (d & 32'hFFFF) * 32'h0001_0001; end
      default: begin be = 4'hF;       wd = d; end
    endcase
  endtask

  task automatic compare();
    check("stall", 32'(mem_stall), 32'(exp_stall));
    check("req", 32'(dmem_req), 32'(exp_req));
    check("fault", 32'(mem_access_fault), 32'(exp_fault));
    check("load_data", mem_memory_data, exp_data);
    if (exp_req) begin
      check("addr", 32'(dmem_addr), 32'(exp_addr));
      check("we", 32'(dmem_we), 32'(exp_we));
      if (exp_we) begin
        check("be", 32'(dmem_be), 32'(exp_be));
        check("wdata", dmem_wdata, exp_wdata);
      end
    end
    if (mem_stall) stall_total++;
  endtask

  task automatic cyc();
    @(negedge clock);
    compare();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    mem_memRead = rd; mem_memWrite = wr; mem_funct3 = f3; mem_ALU_result = a; mem_store_data = sd;
  endtask

  task automatic idle(input int n, input logic stray);
    set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0;
    dmem_rvalid = stray; dmem_rdata = 32'h1234_5678;
    for (int i = 0; i < n; i++) cyc();
    dmem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                         input int r, input int v);
    int s0;
    s0 = stall_total;
    set_op(1'b1, 1'b0, f3, a, 32'h0);
    exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0; exp_we = 1'b0;
    exp_addr = 20'((a >> 2) & 32'hFFFFF);
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    cyc();
    exp_req = 1'b1;
    for (int i = 0; i < r; i++) cyc();
    dmem_ready = 1'b1; dmem_rvalid = (v == 0); dmem_rdata = (v == 0) ? word : ~word;
    cyc();
    dmem_ready = 1'b0; exp_req = 1'b0;
    for (int i = 0; i < v; i++) begin
      dmem_rvalid = (i == v - 1);
      dmem_rdata  = (i == v - 1) ? word : ~word;
      cyc();
    end
    dmem_rvalid = 1'b0; exp_stall = 1'b0; exp_data = model_load(word, f3, a);
    cyc();
    check("load_stall_cycles", 32'(stall_total - s0), 32'(2 + r + v));
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd, input int r);
    int s0;
    s0 = stall_total;
    set_op(1'b0, 1'b1, f3, a, sd);
    exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0; exp_we = 1'b1;
    exp_addr = 20'((a >> 2) & 32'hFFFFF);
    model_store(f3, a, sd, exp_be, exp_wdata);
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    cyc();
    exp_req = 1'b1;
    for (int i = 0; i < r; i++) cyc();
    dmem_ready = 1'b1;
    cyc();
    dmem_ready = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
    cyc();
    check("store_stall_cycles", 32'(stall_total - s0), 32'(2 + r));
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    set_op(rd, wr, f3, a, 32'hFFFF_FFFF);
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b1;
    cyc();
    exp_fault = 1'b0;
    idle(1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [3:0]  pin_be;
    logic [31:0] pin_wd;
    int          s0;

    reset = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    set_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_fault = 1'b0; exp_we = 1'b0;
    exp_addr = 20'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_we", 32'(dmem_we), 32'h0);
    check("rst_addr", 32'(dmem_addr), 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_be", 32'(dmem_be), 32'h0);
    check("rst_data", mem_memory_data, 32'h0);
    check("rst_stall", 32'(mem_stall), 32'h0);
    check("rst_fault", 32'(mem_access_fault), 32'h0);
    reset = 1'b0;
    idle(1, 1'b0);

    check("model_lb", model_load(32'h80FF_0000, 3'b000, 32'h103), 32'hFFFF_FF80);
    check("model_lbu", model_load(32'h80FF_0000, 3'b100, 32'h103), 32'h0000_0080);
    check("model_lhu", model_load(32'h80FF_0000, 3'b101, 32'h102), 32'h0000_80FF);
    model_store(3'b001, 32'h202, 32'h1234_ABCD, pin_be, pin_wd);
    check("model_sh_be", 32'(pin_be), 32'hC);
    check("model_sh_wdata", pin_wd, 32'hABCD_ABCD);

    do_load(3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0);
    check("lw_data_literal", mem_memory_data, 32'hDEAD_BEEF);
    check("lw_addr_literal", 32'(dmem_addr), 32'h40);
    do_load(3'b000, 32'h103, 32'h80FF_0000, 0, 0);
    do_load(3'b100, 32'h103, 32'h80FF_0000, 0, 0);
    do_load(3'b101, 32'h102, 32'h80FF_0000, 1, 0);
    do_load(3'b001, 32'h102, 32'h80FF_1234, 0, 2);
    do_load(3'b000, 32'h101, 32'h0000_7F00, 2, 1);
    do_load(3'b100, 32'h102, 32'hA5C3_0000, 0, 0);
    idle(2, 1'b1);

    do_store(3'b001, 32'h202, 32'h1234_ABCD, 3);
    do_store(3'b000, 32'h201, 32'h0000_0077, 0);
    do_store(3'b010, 32'h300, 32'hCAFE_F00D, 1);
    do_load(3'b010, 32'h300, 32'h0BAD_F00D, 0, 0);

    do_fault(1'b1, 1'b0, 3'b010, 32'h101);
    do_fault(1'b1, 1'b1, 3'b010, 32'h100);
    do_fault(1'b1, 1'b0, 3'b011, 32'h100);
    do_fault(1'b0, 1'b1, 3'b100, 32'h100);
    do_fault(1'b1, 1'b0, 3'b001, 32'h101);
    do_fault(1'b1, 1'b0, 3'b111, 32'h100);

`ifdef MEM_ACCESS_WATCHDOG_EN
    s0 = stall_total;
    set_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    exp_stall = 1'b1; exp_req = 1'b0; exp_fault = 1'b0; exp_we = 1'b0;
    exp_addr = 20'h100; dmem_ready = 1'b0;
    cyc();
    exp_req = 1'b1;
    for (int i = 0; i < 255; i++) cyc();
    exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b1; exp_data = 32'h0;
    cyc();
    check("wd_stall_cycles", 32'(stall_total - s0), 32'd256);
    idle(1, 1'b0);
`else
    s0 = 0;
`endif

    set_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    exp_stall = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 20'h140;
    cyc();
    exp_req = 1'b1; dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    cyc();
    dmem_ready = 1'b0; exp_req = 1'b0;
    cyc();
    reset = 1'b1; set_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0); exp_stall = 1'b0;
    cyc();
    reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h55; exp_data = 32'h0;
    cyc();
    check("rst2_we", 32'(dmem_we), 32'h0);
    check("rst2_addr", 32'(dmem_addr), 32'h0);
    check("rst2_wdata", dmem_wdata, 32'h0);
    check("rst2_be", 32'(dmem_be), 32'h0);
    check("rst2_data", mem_memory_data, 32'h0);
    dmem_rvalid = 1'b0;
    idle(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
